// File: rtl/multadd_arbiter_pkg.sv
// Shared widths, operand bundle and index helper for the multiply-add arbiter.
// Combinational definitions only; no latency and no flow control of their own.
package multadd_arbiter_pkg;

  localparam int MA_AW = 16;
  localparam int MA_BW = 16;
  localparam int MA_CW = 32;
  localparam int MA_PW = 32;

  typedef struct packed {
    logic             subtract;
    logic [MA_AW-1:0] a;
    logic [MA_BW-1:0] b;
    logic [MA_CW-1:0] c;
  } ma_op_t;

  // Successor of idx in a ring of n requesters.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single grant over NREQ requests; grant is combinational, pointer updates on the edge.
// Grant is withheld while en is low or rst is high; the pointer then holds.
module rr_arbiter
  import multadd_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_vld
);

  logic [IDW-1:0] ptr;
  int             scan_idx;

  // Search upward from ptr, wrapping; the first valid requester wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    scan_idx = 0;
    if (en && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = (int'(ptr) + k) % NREQ;
        if (!gnt_vld && req[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDW'(scan_idx);
        end
      end
      if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= IDW'(next_idx(int'(gnt_idx), NREQ));
    end
  end

endmodule

// File: rtl/multadd_arbiter.sv
// Shares one external multiply-add among NREQ requesters; results return tagged with the issuer's id.
// Accept-to-result is LATENCY+1 cycles at one op per cycle; no result back-pressure, every strobe must be taken.
module multadd_arbiter
  import multadd_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_subtract,
  input  logic [NREQ*MA_AW-1:0] req_a,
  input  logic [NREQ*MA_BW-1:0] req_b,
  input  logic [NREQ*MA_CW-1:0] req_c,
  output logic                  ma_subtract,
  output logic [MA_AW-1:0]      ma_a,
  output logic [MA_BW-1:0]      ma_b,
  output logic [MA_CW-1:0]      ma_c,
  input  logic [MA_PW-1:0]      ma_p,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [MA_PW-1:0]      res_p,
  output logic                  busy
);

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            xfer;
  ma_op_t          op_sel;
  ma_op_t          op_q;
  logic [LATENCY:0] tag_vld;
  logic [IDW-1:0]   tag_id [LATENCY+1];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (xfer)
  );

  assign req_ready = gnt;

  always_comb begin
    op_sel          = '0;
    op_sel.subtract = req_subtract[gnt_idx];
    op_sel.a        = req_a[int'(gnt_idx)*MA_AW +: MA_AW];
    op_sel.b        = req_b[int'(gnt_idx)*MA_BW +: MA_BW];
    op_sel.c        = req_c[int'(gnt_idx)*MA_CW +: MA_CW];
  end

  // Operands only change on a transfer; validity downstream is carried by the tag alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
    end else if (xfer) begin
      op_q <= op_sel;
    end
  end

  assign ma_subtract = op_q.subtract;
  assign ma_a        = op_q.a;
  assign ma_b        = op_q.b;
  assign ma_c        = op_q.c;

  // Tag stage s lines up with the MultAdd's internal stage s, so the last stage marks ma_p valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int s = 0; s <= LATENCY; s++) tag_id[s] <= '0;
    end else begin
      tag_vld[0] <= xfer;
      tag_id[0]  <= gnt_idx;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_p     <= '0;
    end else begin
      res_valid <= tag_vld[LATENCY];
      if (tag_vld[LATENCY]) begin
        res_id <= tag_id[LATENCY];
        res_p  <= ma_p;
      end
    end
  end

  assign busy = (|tag_vld) | res_valid;

endmodule

// File: tb/tb_multadd_arbiter.sv
// Drives identical random traffic into a LATENCY=0 and a LATENCY=3 instance, each with its own MultAdd model,
// and compares grants, operand drive and tagged results against a queue-based reference.
module tb_multadd_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en;
  logic [N-1:0]    req_valid, req_subtract;
  logic [N*16-1:0] req_a, req_b;
  logic [N*32-1:0] req_c;

  logic [N-1:0] req_ready   [2];
  logic         ma_subtract [2];
  logic [15:0]  ma_a        [2];
  logic [15:0]  ma_b        [2];
  logic [31:0]  ma_c        [2];
  logic [31:0]  ma_p        [2];
  logic         res_valid   [2];
  logic [1:0]   res_id      [2];
  logic [31:0]  res_p       [2];
  logic         busy        [2];
  logic [31:0]  pipe        [3];

  multadd_arbiter #(.NREQ(N), .IDW(2), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_subtract(req_subtract), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .ma_subtract(ma_subtract[0]), .ma_a(ma_a[0]), .ma_b(ma_b[0]), .ma_c(ma_c[0]), .ma_p(ma_p[0]),
    .res_valid(res_valid[0]), .res_id(res_id[0]), .res_p(res_p[0]), .busy(busy[0])
  );

  multadd_arbiter #(.NREQ(N), .IDW(2), .LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_subtract(req_subtract), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .ma_subtract(ma_subtract[1]), .ma_a(ma_a[1]), .ma_b(ma_b[1]), .ma_c(ma_c[1]), .ma_p(ma_p[1]),
    .res_valid(res_valid[1]), .res_id(res_id[1]), .res_p(res_p[1]), .busy(busy[1])
  );

  function automatic logic [31:0] madd(input logic s, input logic [15:0] a, input logic [15:0] b,
                                       input logic [31:0] c);
    longint prod, r;
    prod = longint'($signed(a)) * longint'($signed(b));
    r    = s ? longint'($signed(c)) - prod : longint'($signed(c)) + prod;
    return r[31:0];
  endfunction

  assign ma_p[0] = madd(ma_subtract[0], ma_a[0], ma_b[0], ma_c[0]);
  assign ma_p[1] = pipe[2];
  always @(posedge clk) begin
    pipe[0] <= madd(ma_subtract[1], ma_a[1], ma_b[1], ma_c[1]);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  typedef struct {
    int          acc;
    int          id;
    logic [31:0] p;
  } exp_t;

  exp_t        log_q[$];
  int          head [2];
  int          ptr_m, cyc, n_chk, n_fail;
  logic [31:0] res_p_h  [2];
  logic [1:0]  res_id_h [2];
  logic        ma_s_e;
  logic [15:0] ma_a_e, ma_b_e;
  logic [31:0] ma_c_e;
  logic        gold_on;
  logic [31:0] gold_p;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic set_op(input int i, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] c);
    req_subtract[i]    = s;
    req_a[i*16 +: 16]  = a;
    req_b[i*16 +: 16]  = b;
    req_c[i*32 +: 32]  = c;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, 1'($urandom_range(0, 1)), pick16(), pick16(), pick32());
  endtask

  // One cycle: apply inputs after the falling edge, check the combinational grant,
  // advance the reference, then check registered outputs after the next rising edge.
  task automatic step(input logic rv, input logic ev, input logic [N-1:0] vv);
    int       gi;
    logic [N-1:0] gexp;
    exp_t     ent;
    logic     strobe;
    rst = rv; en = ev; req_valid = vv;
    #1;
    if (rv) begin
      ptr_m  = 0;
      ma_s_e = 1'b0; ma_a_e = '0; ma_b_e = '0; ma_c_e = '0;
      for (int d = 0; d < 2; d++) begin
        head[d]     = log_q.size();
        res_p_h[d]  = '0;
        res_id_h[d] = '0;
        chk($sformatf("d%0d rst res_valid", d), 64'(res_valid[d]), 64'd0);
        chk($sformatf("d%0d rst res_p", d), 64'(res_p[d]), 64'd0);
        chk($sformatf("d%0d rst res_id", d), 64'(res_id[d]), 64'd0);
        chk($sformatf("d%0d rst busy", d), 64'(busy[d]), 64'd0);
        chk($sformatf("d%0d rst ma_c", d), 64'(ma_c[d]), 64'd0);
      end
    end
    gi   = -1;
    gexp = '0;
    if (!rv && ev)
      for (int k = 0; k < N; k++)
        if (gi < 0 && vv[(ptr_m + k) % N]) gi = (ptr_m + k) % N;
    if (gi >= 0) gexp[gi] = 1'b1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("d%0d req_ready", d), 64'(req_ready[d]), 64'(gexp));
    if (gi >= 0) begin
      ent.acc = cyc + 1;
      ent.id  = gi;
      ent.p   = gold_on ? gold_p
                        : madd(req_subtract[gi], req_a[gi*16 +: 16], req_b[gi*16 +: 16], req_c[gi*32 +: 32]);
      log_q.push_back(ent);
      ma_s_e = req_subtract[gi];
      ma_a_e = req_a[gi*16 +: 16];
      ma_b_e = req_b[gi*16 +: 16];
      ma_c_e = req_c[gi*32 +: 32];
      ptr_m  = (gi + 1) % N;
    end
    gold_on = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      strobe = (head[d] < log_q.size()) && (log_q[head[d]].acc + 1 + lat(d) == cyc);
      if (strobe) begin
        res_id_h[d] = 2'(log_q[head[d]].id);
        res_p_h[d]  = log_q[head[d]].p;
        head[d]++;
      end
      chk($sformatf("d%0d res_valid", d), 64'(res_valid[d]), 64'(strobe));
      chk($sformatf("d%0d res_id", d), 64'(res_id[d]), 64'(res_id_h[d]));
      chk($sformatf("d%0d res_p", d), 64'(res_p[d]), 64'(res_p_h[d]));
      chk($sformatf("d%0d busy", d), 64'(busy[d]), 64'(strobe || (head[d] < log_q.size())));
      chk($sformatf("d%0d ma_op", d), {15'd0, ma_subtract[d], ma_a[d], ma_b[d], ma_c[d]},
          {15'd0, ma_s_e, ma_a_e, ma_b_e, ma_c_e});
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; ptr_m = 0; gold_on = 1'b0; gold_p = '0;
    head[0] = 0; head[1] = 0;
    res_p_h[0] = '0; res_p_h[1] = '0; res_id_h[0] = '0; res_id_h[1] = '0;
    ma_s_e = 1'b0; ma_a_e = '0; ma_b_e = '0; ma_c_e = '0;
    rst = 1'b1; en = 1'b0; req_valid = '0; req_subtract = '0;
    req_a = '0; req_b = '0; req_c = '0;
    @(negedge clk);

    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hF);
    step(1'b0, 1'b0, 4'h0);

    set_op(2, 1'b0, 16'h4FFF, 16'h4FFF, 32'h4FFF_FFFF);
    gold_on = 1'b1; gold_p = 32'h68FF_6000;
    step(1'b0, 1'b1, 4'b0100);
    repeat (5) step(1'b0, 1'b1, 4'h0);

    set_op(0, 1'b0, 16'hFFF0, 16'h4000, 32'h0);
    gold_on = 1'b1; gold_p = 32'hFFFC_0000;
    step(1'b0, 1'b1, 4'b0001);
    set_op(0, 1'b1, 16'hFFF0, 16'h4000, 32'h0);
    gold_on = 1'b1; gold_p = 32'h0004_0000;
    step(1'b0, 1'b1, 4'b0001);
    repeat (5) step(1'b0, 1'b1, 4'h0);

    step(1'b1, 1'b0, 4'h0);
    repeat (8) begin rand_ops(); step(1'b0, 1'b1, 4'hF); end
    repeat (5) step(1'b0, 1'b1, 4'h0);

    repeat (5) begin rand_ops(); step(1'b0, 1'b1, 4'b0010); end
    repeat (6) step(1'b0, 1'b1, 4'h0);

    rand_ops(); step(1'b0, 1'b1, 4'b1000);
    rand_ops(); step(1'b0, 1'b1, 4'b0001);
    repeat (3) step(1'b0, 1'b0, 4'hF);
    rand_ops(); step(1'b0, 1'b1, 4'hF);
    repeat (5) step(1'b0, 1'b1, 4'h0);

    rand_ops(); step(1'b0, 1'b1, 4'b0100);
    rand_ops(); step(1'b0, 1'b1, 4'b0100);
    step(1'b1, 1'b1, 4'hF);
    rand_ops(); step(1'b0, 1'b1, 4'b1010);
    repeat (5) step(1'b0, 1'b1, 4'h0);

    repeat (400) begin
      rand_ops();
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 99) < 85), 4'($urandom));
    end
    repeat (6) step(1'b0, 1'b1, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
